// File: rtl/bin_to_bcd_seq.sv
// Sequential 10-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
// Optional zero-blanking flags on output port blank when BIN_TO_BCD_BLANK_EN is defined.
module bin_to_bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
`ifdef BIN_TO_BCD_BLANK_EN
  ,
  output logic [3:0]  blank
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  sh_q, sh_d;
  logic [15:0] scr_q, scr_d;
  logic [15:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] scr_adj;
  logic [15:0] scr_next;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [3:0]  blank_q, blank_d;
`endif

  always_comb begin
    scr_adj = scr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    // The bit shifted out of the thousands nibble is always 0 for inputs <= 1023.
    scr_next = (scr_adj << 1) | {15'b0, sh_q[9]};

    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
    blank_d = blank_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          state_d = SHIFT;
          sh_d    = bin;
          scr_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        sh_d   = {sh_q[8:0], 1'b0};
        scr_d  = scr_next;
        cnt_d  = cnt_q + 4'd1;
        busy_d = 1'b1;
        if (cnt_q == 4'd9) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = scr_next;
`ifdef BIN_TO_BCD_BLANK_EN
          blank_d[3] = (scr_next[15:12] == 4'd0);
          blank_d[2] = blank_d[3] && (scr_next[11:8] == 4'd0);
          blank_d[1] = blank_d[2] && (scr_next[7:4] == 4'd0);
          blank_d[0] = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BIN_TO_BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BIN_TO_BCD_BLANK_EN
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  bin = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [3:0]  blank;
`endif

  int checks = 0;
  int passed = 0;

  bin_to_bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef BIN_TO_BCD_BLANK_EN
    ,
    .blank (blank)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse start for one edge; returns #1 after the accepting edge.
  task automatic kick(input logic [9:0] v);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycles from the accepting edge until done is seen; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) lat = i;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd5;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (bcd !== 16'h0000) $display("FAIL reset_bcd: got %h want 0000", bcd); else passed++;
`ifdef BIN_TO_BCD_BLANK_EN
    checks++; if (blank !== 4'b0000) $display("FAIL reset_blank: got %b want 0000", blank); else passed++;
`endif
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL start_during_rst_ignored: busy %b want 0", busy); else passed++;
  endtask

  task automatic test_max;
    int lat;
    int nb;
    kick(10'd1023);
    checks++; if (busy !== 1'b1) $display("FAIL max_busy_rise: got %b want 1", busy); else passed++;
    nb  = 1;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) lat = i;
      else if (busy === 1'b1) nb++;
    end
    checks++; if (lat != 10) $display("FAIL max_latency: got %0d want 10", lat); else passed++;
    checks++; if (nb != 10) $display("FAIL max_busy_cycles: got %0d want 10", nb); else passed++;
    checks++; if (bcd !== 16'h1023) $display("FAIL max_bcd: got %h want 1023", bcd); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL max_busy_at_done: got %b want 0", busy); else passed++;
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) $display("FAIL max_done_width: got %b want 0", done); else passed++;
    checks++; if (bcd !== 16'h1023) $display("FAIL max_bcd_hold: got %h want 1023", bcd); else passed++;
  endtask

  task automatic test_zero_mid;
    logic [9:0]  vin [3];
    logic [15:0] vexp [3];
    logic [3:0]  bexp [3];
    int lat;
    vin[0] = 10'd0;   vexp[0] = 16'h0000; bexp[0] = 4'b1110;
    vin[1] = 10'd599; vexp[1] = 16'h0599; bexp[1] = 4'b1000;
    vin[2] = 10'd7;   vexp[2] = 16'h0007; bexp[2] = 4'b1110;
    for (int t = 0; t < 3; t++) begin
      kick(vin[t]);
      wait_done(lat);
      checks++; if (lat != 10) $display("FAIL zm_latency[%0d]: got %0d want 10", vin[t], lat); else passed++;
      checks++; if (bcd !== vexp[t]) $display("FAIL zm_bcd[%0d]: got %h want %h", vin[t], bcd, vexp[t]); else passed++;
`ifdef BIN_TO_BCD_BLANK_EN
      checks++; if (blank !== bexp[t]) $display("FAIL zm_blank[%0d]: got %b want %b", vin[t], blank, bexp[t]); else passed++;
`endif
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) $display("FAIL zm_done_width[%0d]: got %b want 0", vin[t], done); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    bin   = 10'd250;
    start = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_rise: got %b want 1", busy); else passed++;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) bin = 10'd999;
      if (done === 1'b1) lat = i;
    end
    checks++; if (lat != 10) $display("FAIL b2b_first_latency: got %0d want 10", lat); else passed++;
    checks++; if (bcd !== 16'h0250) $display("FAIL b2b_first_bcd: got %h want 0250", bcd); else passed++;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_restart_busy: got %b want 1", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL b2b_restart_done: got %b want 0", done); else passed++;
    checks++; if (bcd !== 16'h0250) $display("FAIL b2b_bcd_hold: got %h want 0250", bcd); else passed++;
    wait_done(lat);
    checks++; if (lat != 10) $display("FAIL b2b_second_latency: got %0d want 10", lat); else passed++;
    checks++; if (bcd !== 16'h0999) $display("FAIL b2b_second_bcd: got %h want 0999", bcd); else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen;
    kick(10'd512);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rmid_async_busy: got %b want 0", busy); else passed++;
    checks++; if (bcd !== 16'h0000) $display("FAIL rmid_async_bcd: got %h want 0000", bcd); else passed++;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL rmid_no_done: got done pulse want none"); else passed++;
    checks++; if (bcd !== 16'h0000) $display("FAIL rmid_bcd_after: got %h want 0000", bcd); else passed++;
    kick(10'd512);
    wait_done(lat);
    checks++; if (lat != 10) $display("FAIL rmid_latency: got %0d want 10", lat); else passed++;
    checks++; if (bcd !== 16'h0512) $display("FAIL rmid_bcd: got %h want 0512", bcd); else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep;
    int lat;
    logic [15:0] e;
`ifdef BIN_TO_BCD_BLANK_EN
    logic [3:0] be;
`endif
    for (int v = 0; v < 1024; v++) begin
      e[15:12] = 4'(v / 1000);
      e[11:8]  = 4'((v / 100) % 10);
      e[7:4]   = 4'((v / 10) % 10);
      e[3:0]   = 4'(v % 10);
      kick(10'(v));
      wait_done(lat);
      checks++; if (lat != 10) $display("FAIL sweep_latency[%0d]: got %0d want 10", v, lat); else passed++;
      checks++; if (bcd !== e) $display("FAIL sweep_bcd[%0d]: got %h want %h", v, bcd, e); else passed++;
`ifdef BIN_TO_BCD_BLANK_EN
      be[3] = (v < 1000);
      be[2] = (v < 100);
      be[1] = (v < 10);
      be[0] = 1'b0;
      checks++; if (blank !== be) $display("FAIL sweep_blank[%0d]: got %b want %b", v, blank, be); else passed++;
`endif
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) $display("FAIL sweep_done_width[%0d]: got %b want 0", v, done); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_zero_mid();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have no parameters; widths are fixed: 10-bit binary in, 4-digit BCD out.
REQ-002 SHALL have port clk, input, 1 bit: single system clock, all state on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request conversion of bin; sampled on clk.
REQ-005 SHALL have port bin, input, 10 bits: unsigned binary operand (0..1023), sampled only when start is accepted.
REQ-006 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse indicating that bcd holds a new result.
REQ-008 SHALL have port bcd, output, 16 bits: {thousands, hundreds, tens, ones} digits, 4 bits each, registered.

Function
REQ-009 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-010 In IDLE or DONE, start=1 at edge k SHALL be accepted: bin is captured into the shift register, the BCD scratch is cleared, the iteration counter is set to 0, and the FSM enters SHIFT.
REQ-011 In SHIFT, each edge SHALL perform one double-dabble step on the scratch register:
- add 3 to every BCD nibble that is >= 5;
- then shift the combined {scratch, binary} register left by 1;
- increment the iteration counter.
REQ-012 After the 10th SHIFT step (edge k+10), the FSM SHALL load bcd with the scratch result and enter DONE; done=1 and busy=0 SHALL hold from edge k+10 until edge k+11.
REQ-013 The state SHALL move from DONE to IDLE at the next edge, unless start=1 causes a new conversion to be accepted per REQ-010.
REQ-014 busy SHALL be 1 exactly while in SHIFT, i.e. from edge k to edge k+10.
REQ-015 Latency from an accepted start to the done pulse SHALL be exactly 10 cycles.
REQ-016 start while busy=1 SHALL be ignored, with no effect on state, counter, bin capture or bcd.
REQ-017 bcd SHALL hold the last result unchanged until the next completion.
REQ-018 Scratch nibbles SHALL be wide enough for the result range 0..1023 without overflow, so the thousands digit is only ever 0 or 1.
REQ-019 The iteration counter SHALL be 4 bits and SHALL reset to 0 on every accepted start.

Reset
REQ-020 rst=1 SHALL asynchronously force:
- state to IDLE;
- busy=0 and done=0;
- bcd=16'h0000;
- the counter and all scratch registers to 0.
REQ-021 rst asserted mid-conversion SHALL abort it with no done pulse; after rst is released, the next accepted start SHALL convert normally.
REQ-022 start SHALL be ignored while rst=1.

Configuration
REQ-023 When macro BIN_TO_BCD_BLANK_EN is defined, the block SHALL add the following port and behaviour:
- output blank, 4 bits, registered and loaded together with bcd;
- blank[i]=1 when digit i and all more-significant digits are 0;
- blank[0] SHALL always be 0;
- blank SHALL reset to 4'b0000.
REQ-024 When BIN_TO_BCD_BLANK_EN is undefined, the blank port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 Conversion of maximum value: bin=1023 with start pulse -> done exactly 10 cycles later, bcd=16'h1023, busy high for 10 cycles.
REQ-026 Conversion of zero and a mid value:
- bin=0 -> bcd=16'h0000;
- bin=599 -> bcd=16'h0599;
- with BIN_TO_BCD_BLANK_EN, bin=599 -> blank=4'b1000;
- with BIN_TO_BCD_BLANK_EN, bin=7 -> blank=4'b1110.
REQ-027 start held high throughout a conversion of 250, with bin changed to 999 at cycle 3 -> first result bcd=16'h0250 (the mid-conversion start is ignored); start seen in the DONE cycle then begins a back-to-back conversion -> bcd=16'h0999 ten cycles later.
REQ-028 rst pulsed at cycle 5 of a conversion of 512 -> no done pulse, bcd=16'h0000; a following start with bin=512 -> bcd=16'h0512 after 10 cycles.
REQ-029 Exhaustive sweep of bin=0..1023, each converted in turn -> every bcd matches the decimal reference and every done pulse is exactly 1 cycle wide.
